// File: rtl/cordic_logarithm_8bit_if.sv
// Handshake bundle for the CORDIC natural-log unit: the requester drives
// start/w_in, the unit returns busy/done plus the held result.
interface cordic_logarithm_8bit_if #(
    parameter int XY_SZ = 8
);
    logic                    start;
    logic [XY_SZ-1:0]        w_in;
    logic                    busy;
    logic                    done;
    logic signed [31:0]      ln_out;
    logic                    range_err;

    modport master (
        output start, w_in,
        input  busy, done, ln_out, range_err
    );

    modport slave (
        input  start, w_in,
        output busy, done, ln_out, range_err
    );
endinterface

// File: rtl/cordic_logarithm_8bit.sv
// Iterative hyperbolic-vectoring CORDIC natural logarithm.
// ln(w) = 2*atanh((w-1)/(w+1)): x/y are loaded with w+1 / w-1, y is driven
// to zero one micro-rotation per clock, and the accumulated angle z is doubled.
// Shift schedule 1,2,3,4,4,5..ITERS (the repeat of 4 keeps the hyperbolic
// iteration convergent).
module cordic_logarithm_8bit #(
    parameter int XY_SZ = 8,
    parameter int ITERS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_logarithm_8bit_if.slave bus
);
    localparam int FRAC = XY_SZ - 3;
    localparam int XW   = XY_SZ + 9;

    // Counter value after the last micro-rotation; seeing it in ROT means
    // the angle is complete and the result can be captured.
    localparam logic [3:0]              CNT_END = 4'(ITERS + 1);
    localparam logic [3:0]              CNT_REP = 4'd4;
    localparam logic signed [XW-1:0]    ONE     = XW'(2 ** FRAC);
    localparam logic [XY_SZ-1:0]        W_MIN   = XY_SZ'(4);
    localparam logic signed [31:0]      LN_ERR  = 32'sh8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [XW-1:0]   x_q, y_q;
    logic signed [XW-1:0]   xs, ys, w_ext;
    logic signed [31:0]     z_q;
    logic signed [31:0]     ln_q;
    logic [3:0]             cnt_q;
    logic                   rep_q;
    logic                   rerr_q;
    logic                   rerr_out_q;
    logic                   accept, rot_en, finish, busy_c, done_c;

    // atanh(2^-i) in Q3.29, rounded to nearest.
    function automatic logic signed [31:0] atanh_lut(input logic [3:0] i);
        case (i)
            4'd1:    atanh_lut = 32'sd294906491;
            4'd2:    atanh_lut = 32'sd137123709;
            4'd3:    atanh_lut = 32'sd67461703;
            4'd4:    atanh_lut = 32'sd33598225;
            4'd5:    atanh_lut = 32'sd16782681;
            4'd6:    atanh_lut = 32'sd8389291;
            4'd7:    atanh_lut = 32'sd4194389;
            4'd8:    atanh_lut = 32'sd2097163;
            4'd9:    atanh_lut = 32'sd1048577;
            4'd10:   atanh_lut = 32'sd524288;
            4'd11:   atanh_lut = 32'sd262144;
            4'd12:   atanh_lut = 32'sd131072;
            default: atanh_lut = 32'sd0;
        endcase
    endfunction

    // Doubles the half-angle into ln(w); |z| < 1.05 so no saturation is
    // possible. Out-of-range operands return the most negative code.
    function automatic logic signed [31:0] ln_format(input logic signed [31:0] z,
                                                     input logic err);
        ln_format = err ? LN_ERR : (z <<< 1);
    endfunction

    assign w_ext = {{(XW - XY_SZ){1'b0}}, bus.w_in};
    assign xs    = x_q >>> cnt_q;
    assign ys    = y_q >>> cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; OUT also accepts so a held start
    // re-issues with no idle gap.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rot_en  = 1'b0;
        finish  = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ROT;
                end
            end
            ROT: begin
                busy_c = 1'b1;
                if (cnt_q == CNT_END) begin
                    finish  = 1'b1;
                    state_d = OUT;
                end else begin
                    rot_en = 1'b1;
                end
            end
            OUT: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ROT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand load and one micro-rotation per clock; both x and y updates
    // use the pre-update values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            rep_q  <= 1'b0;
            rerr_q <= 1'b0;
        end else if (accept) begin
            x_q    <= (w_ext + ONE) <<< 6;
            y_q    <= (w_ext - ONE) <<< 6;
            z_q    <= '0;
            cnt_q  <= 4'd1;
            rep_q  <= 1'b0;
            rerr_q <= (bus.w_in < W_MIN);
        end else if (rot_en) begin
            if (!y_q[XW-1]) begin
                x_q <= x_q - ys;
                y_q <= y_q - xs;
                z_q <= z_q + atanh_lut(cnt_q);
            end else begin
                x_q <= x_q + ys;
                y_q <= y_q + xs;
                z_q <= z_q - atanh_lut(cnt_q);
            end
            if (cnt_q == CNT_REP && !rep_q) begin
                rep_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Result capture; held until the next completed operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ln_q       <= '0;
            rerr_out_q <= 1'b0;
        end else if (finish) begin
            ln_q       <= ln_format(z_q, rerr_q);
            rerr_out_q <= rerr_q;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.ln_out    = ln_q;
    assign bus.range_err = rerr_out_q;
endmodule

// File: tb/tb_cordic_logarithm_8bit.sv
// Self-checking bench for cordic_logarithm_8bit: directed corner operands,
// handshake behaviour, async reset mid-computation, full sweep and random
// operands against a real-valued natural-log model.
module tb_cordic_logarithm_8bit;
    localparam longint TOL = 64'sd4194304;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cordic_logarithm_8bit_if #(.XY_SZ(8)) bus ();

    cordic_logarithm_8bit #(.XY_SZ(8), .ITERS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol);
        longint diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: real-valued ln of w_in/32 in units of 2^-29, or the error code.
    function automatic longint model_ln(input int w);
        if (w < 4) return -(longint'(1) <<< 31);
        return longint'($ln(real'(w) / 32.0) * 536870912.0);
    endfunction

    task automatic run_op(input logic [7:0] w, output int lat,
                          output longint lnv, output logic re);
        @(negedge clk);
        bus.start = 1'b1;
        bus.w_in  = w;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        lnv = bus.ln_out;
        re  = bus.range_err;
    endtask

    task automatic check_op(input string tag, input int w);
        int     lat;
        longint lnv;
        logic   re;
        run_op(8'(w), lat, lnv, re);
        check($sformatf("%s_lat", tag), lat, 12, 0);
        check($sformatf("%s_ln", tag), lnv, model_ln(w), (w < 4) ? 0 : TOL);
        check($sformatf("%s_rerr", tag), re, (w < 4) ? 1 : 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int     lat, cnt, last, pulses;
        longint lnv;
        logic   re;

        bus.start = 1'b0;
        bus.w_in  = '0;

        // Reset state
        #12;
        check("rst_busy", bus.busy, 0, 0);
        check("rst_done", bus.done, 0, 0);
        check("rst_ln", bus.ln_out, 0, 0);
        check("rst_rerr", bus.range_err, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed operands, including the range extremes
        check_op("w32", 32);
        check_op("w87", 87);
        check_op("w16", 16);
        check_op("w255", 255);
        check_op("w4", 4);
        check_op("w0", 0);

        // busy asserted right after acceptance
        @(negedge clk);
        bus.start = 1'b1;
        bus.w_in  = 8'd100;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_on", bus.busy, 1, 0);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_lat", lat, 12, 0);
        check("busy_off", bus.busy, 0, 0);
        check("busy_ln", bus.ln_out, model_ln(100), TOL);

        // start during busy with a different operand is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.w_in  = 8'd87;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.w_in  = 8'd16;
        @(posedge clk);
        #1;
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ign_lat", lat, 12, 0);
        check("ign_ln", bus.ln_out, model_ln(87), TOL);
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        check("ign_noextra", cnt, 0, 0);

        // start held high: done every 13 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.w_in  = 8'd200;
        last   = -1;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (last >= 0) check("b2b_gap", c - last, 13, 0);
                check("b2b_ln", bus.ln_out, model_ln(200), TOL);
                last = c;
                pulses++;
            end
        end
        check("b2b_pulses", pulses, 3, 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (16) @(posedge clk);

        // Async reset mid-rotation clears the held error result
        check_op("w3", 3);
        @(negedge clk);
        bus.start = 1'b1;
        bus.w_in  = 8'd200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0, 0);
        check("arst_done", bus.done, 0, 0);
        check("arst_ln", bus.ln_out, 0, 0);
        check("arst_rerr", bus.range_err, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) cnt++;
        end
        check("arst_nodone", cnt, 0, 0);

        // Exhaustive sweep
        for (int w = 0; w < 256; w++) begin
            run_op(8'(w), lat, lnv, re);
            check($sformatf("sweep%0d_ln", w), lnv, model_ln(w), (w < 4) ? 0 : TOL);
            check($sformatf("sweep%0d_rerr", w), re, (w < 4) ? 1 : 0, 0);
        end

        // Random operands
        repeat (40) begin
            int w;
            w = int'($urandom_range(0, 255));
            check_op($sformatf("rnd%0d", w), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
